switch_debounce: RTL
====================

Name: switch_debounce

Overview:
- Upstream conditioning stage for the SWITCH_INPUT AHB-Lite peripheral.
- Takes raw, asynchronous, bouncing board slide-switch levels and outputs a clean, synchronised, debounced vector. That vector drives SWITCH_INPUT.SWITCH directly.
- Also emits a one-cycle change strobe, for use as an event source or an IRQ qualifier.

Parameters:
- SW_WIDTH, 15, number of switch bits; matches the SWITCH_INPUT port width.
- TICK_DIV, 1000, HCLK cycles per debounce sample tick; must be >= 1.
- DB_TICKS, 10, consecutive mismatching ticks needed before an output bit flips; must be >= 1.

Ports:
- HCLK  in  1  system clock, shared with the AHB-Lite bus.
- HRESET  in  1  synchronous, active-high reset.
- SW_RAW  in  SW_WIDTH  raw asynchronous switch pins.
- SWITCH  out  SW_WIDTH  debounced stable level; connects to SWITCH_INPUT.SWITCH.
- SWITCH_CHANGE  out  1  one-cycle pulse in the cycle any SWITCH bit changes.
- TICK  out  1  prescaler tick; debug/visibility only.

Behaviour:
- Clocking and reset:
  - Single clock HCLK.
  - HRESET is sampled on the HCLK rising edge only, and overrides all other activity.
  - On reset: sync flops = 0, prescaler = 0, all per-bit counters = 0, SWITCH = 0, SWITCH_CHANGE = 0, TICK = 0.
  - The first cycle after reset release behaves identically to any idle cycle.
- Synchroniser:
  - Two flops per bit, SW_RAW -> s1 -> s2. Only s2 is used downstream.
  - No logic sits between s1 and s2.
- Prescaler:
  - Counter 0..TICK_DIV-1; wraps to 0.
  - TICK is registered and high for exactly one cycle when the counter equals TICK_DIV-1.
  - TICK_DIV = 1 gives TICK continuously high.
  - The counter free-runs; it is not restarted by input activity.
- Per-bit FSM, with states STABLE and COUNT:
  - STABLE: if s2[i] == SWITCH[i], stay; cnt[i] = 0. If s2[i] != SWITCH[i], go to COUNT.
  - COUNT:
    - If s2[i] == SWITCH[i] (bounce back), clear cnt[i] and return to STABLE. This takes priority over a coincident TICK.
    - Otherwise, on TICK: if cnt[i] == DB_TICKS-1, then SWITCH[i] <= s2[i], cnt[i] <= 0, return to STABLE. Else cnt[i]++.
    - Without TICK, hold.
- Counter width: $clog2(DB_TICKS) with a minimum of 1. The counter never exceeds DB_TICKS-1, so no wrap is possible.
- Latency:
  - An SW_RAW step held steady becomes visible on SWITCH after 2 sync cycles plus DB_TICKS ticks.
  - Bounds are [2 + (DB_TICKS-1)*TICK_DIV + 1, 2 + DB_TICKS*TICK_DIV + 1] HCLK cycles.
- Glitch rejection: any s2 pulse shorter than DB_TICKS ticks is never propagated.
- SWITCH_CHANGE:
  - Registered OR of all per-bit flip events; asserted in the same cycle SWITCH updates.
  - Multiple bits flipping in the same cycle give a single pulse.
- Independence: bits are independent. Simultaneous changes on several bits settle independently, and may flip in the same or different ticks.
- Reset mid-count: counters clear, SWITCH returns to 0, and no SWITCH_CHANGE pulse occurs in the reset cycle.

Optional Feature:
- Macro: SWITCH_DEBOUNCE_EDGE_EN.
- When defined, two extra outputs are added:
  - SW_RISE  out  SW_WIDTH: per-bit one-cycle pulse when SWITCH[i] goes 0->1.
  - SW_FALL  out  SW_WIDTH: per-bit one-cycle pulse when SWITCH[i] goes 1->0.
  - Both are coincident with SWITCH_CHANGE and reset to 0.
- When undefined, these ports and their flops do not exist; all other behaviour is identical.

Decomposition:
- Package switch_pkg holds:
  - SW_WIDTH_DEF = 15, TICK_DIV_DEF = 1000, DB_TICKS_DEF = 10.
  - The enum typedef db_state_t {STABLE, COUNT}.
- Sub-module switch_debounce_bit:
  - Contains one bit's synchroniser, FSM and counter. Inputs: HCLK, HRESET, raw bit, TICK. Outputs: stable bit, flip pulse.
  - Instantiated SW_WIDTH times with a generate loop.
- The top level owns the prescaler, the SWITCH_CHANGE OR-reduction and the optional edge outputs.

Test Plan (TICK_DIV=4, DB_TICKS=3, SW_WIDTH=15):
- Reset/idle: HRESET=1 for 3 cycles with SW_RAW=15'h7FFF -> SWITCH=0, SWITCH_CHANGE=0, TICK=0 throughout reset.
- Clean step: after reset, set SW_RAW=15'h0011 and hold -> SWITCH becomes 15'h0011 between cycles 11 and 15 after the step, with exactly one SWITCH_CHANGE pulse in that same cycle.
- Bounce rejection: toggle SW_RAW[5] high for 6 cycles, low for 6 cycles, repeated 4 times, then low -> SWITCH[5] stays 0 and no SWITCH_CHANGE pulse occurs.
- Bounce then settle: SW_RAW 15'h0011 -> 15'h0031, with bit 5 bouncing 5 times at 2-cycle spacing before holding -> SWITCH = 15'h0031 within 15 cycles after the last bounce; exactly one pulse.
- Reset mid-count: start a 0->1 step on bit 0, then assert HRESET for 1 cycle, 6 cycles later -> SWITCH stays 0 through and after the reset. After release, SWITCH[0] = 1 within 15 cycles.
- With SWITCH_DEBOUNCE_EDGE_EN defined: SW_RAW 15'h0011 -> 15'h0030 -> SW_RISE = 15'h0020 and SW_FALL = 15'h0001 (each one cycle, coincident if they settle in the same tick), with SWITCH_CHANGE asserted each time.

Source files
------------

// File: rtl/switch_pkg.sv
// switch_pkg: shared defaults and types for the switch debounce block.
//   SW_WIDTH_DEF / TICK_DIV_DEF / DB_TICKS_DEF : default parameter values
//   db_state_t                                 : per-bit debounce FSM state
//   cnt_w()                                    : counter width with a floor of 1 bit
package switch_pkg;
  localparam int SW_WIDTH_DEF = 15;
  localparam int TICK_DIV_DEF = 1000;
  localparam int DB_TICKS_DEF = 10;

  typedef enum logic {STABLE = 1'b0, COUNT = 1'b1} db_state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/switch_debounce_if.sv
// switch_debounce_if: switch-side signal bundle of the debouncer.
//   SW_RAW        raw asynchronous switch pins
//   SWITCH        debounced stable level
//   SWITCH_CHANGE one-cycle pulse when any SWITCH bit changes
//   TICK          prescaler tick (debug)
//   SW_RISE/SW_FALL per-bit edge pulses, only with SWITCH_DEBOUNCE_EDGE_EN
// Modports: slave = debouncer side, master = board/bench side.
interface switch_debounce_if
  import switch_pkg::*;
#(
  parameter int SW_WIDTH = SW_WIDTH_DEF
);
  logic [SW_WIDTH-1:0] SW_RAW;
  logic [SW_WIDTH-1:0] SWITCH;
  logic                SWITCH_CHANGE;
  logic                TICK;
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic [SW_WIDTH-1:0] SW_RISE;
  logic [SW_WIDTH-1:0] SW_FALL;

  modport slave  (input SW_RAW, output SWITCH, SWITCH_CHANGE, TICK, SW_RISE, SW_FALL);
  modport master (output SW_RAW, input SWITCH, SWITCH_CHANGE, TICK, SW_RISE, SW_FALL);
`else
  modport slave  (input SW_RAW, output SWITCH, SWITCH_CHANGE, TICK);
  modport master (output SW_RAW, input SWITCH, SWITCH_CHANGE, TICK);
`endif
endinterface

// File: rtl/switch_debounce_bit.sv
// switch_debounce_bit: one switch bit -- 2-flop synchroniser, STABLE/COUNT
// FSM and tick counter.
//   HCLK, HRESET : clock, synchronous active-high reset
//   raw_i        : raw asynchronous pin
//   tick_i       : prescaler tick (one cycle wide)
//   stable_o     : debounced level
//   flip_o       : combinational pulse in the cycle stable_o is about to change
module switch_debounce_bit
  import switch_pkg::*;
#(
  parameter int DB_TICKS = DB_TICKS_DEF
) (
  input  logic HCLK,
  input  logic HRESET,
  input  logic raw_i,
  input  logic tick_i,
  output logic stable_o,
  output logic flip_o
);
  localparam int            CW       = cnt_w(DB_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_TICKS - 1);

  logic          s1_q, s2_q;
  logic          stable_q, stable_d;
  db_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      state_q  <= STABLE;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    flip_o   = 1'b0;
    case (state_q)
      STABLE: begin
        cnt_d = '0;
        if (s2_q != stable_q) state_d = COUNT;
      end
      COUNT: begin
        // A bounce back wins over a coincident tick.
        if (s2_q == stable_q) begin
          cnt_d   = '0;
          state_d = STABLE;
        end else if (tick_i) begin
          if (cnt_q == CNT_LAST) begin
            stable_d = s2_q;
            cnt_d    = '0;
            state_d  = STABLE;
            flip_o   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign stable_o = stable_q;
endmodule

// File: rtl/switch_debounce.sv
// switch_debounce: synchronises and debounces board slide switches.
//   HCLK, HRESET : clock, synchronous active-high reset
//   sw (slave)   : SW_RAW in; SWITCH, SWITCH_CHANGE, TICK out
// Optional macro SWITCH_DEBOUNCE_EDGE_EN adds registered per-bit SW_RISE /
// SW_FALL pulses, coincident with SWITCH_CHANGE.
module switch_debounce
  import switch_pkg::*;
#(
  parameter int SW_WIDTH = SW_WIDTH_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int DB_TICKS = DB_TICKS_DEF
) (
  input  logic HCLK,
  input  logic HRESET,
  switch_debounce_if.slave sw
);
  localparam int            PW       = cnt_w(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]       pre_q, pre_d;
  logic                tick_q;
  logic                change_q;
  logic [SW_WIDTH-1:0] stable_w, flip_w;

  // Free-running prescaler; never restarted by switch activity.
  always_comb pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pre_q    <= '0;
      tick_q   <= 1'b0;
      change_q <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      tick_q   <= (pre_q == PRE_LAST);
      // Registered alongside the per-bit stable flops, so it lines up with SWITCH.
      change_q <= |flip_w;
    end
  end

  for (genvar i = 0; i < SW_WIDTH; i++) begin : g_bit
    switch_debounce_bit #(.DB_TICKS(DB_TICKS)) u_bit (
      .HCLK    (HCLK),
      .HRESET  (HRESET),
      .raw_i   (sw.SW_RAW[i]),
      .tick_i  (tick_q),
      .stable_o(stable_w[i]),
      .flip_o  (flip_w[i])
    );
  end

  assign sw.SWITCH        = stable_w;
  assign sw.SWITCH_CHANGE = change_q;
  assign sw.TICK          = tick_q;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  logic [SW_WIDTH-1:0] rise_q, fall_q;

  // Direction comes from the pre-flip stable value.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= flip_w & ~stable_w;
      fall_q <= flip_w &  stable_w;
    end
  end

  assign sw.SW_RISE = rise_q;
  assign sw.SW_FALL = fall_q;
`endif
endmodule
